// File: rtl/toggle_seq_pkg.sv
// toggle_seq_pkg: command opcodes and FSM state encoding for toggle_seq_ctrl.
package toggle_seq_pkg;
    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;
endpackage

// File: rtl/toggle_seq_ctrl_t_ff_bank.sv
// t_ff_bank: WIDTH T flip-flops with asynchronous clear; each bit flips when its toggle is set.
module t_ff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] toggle,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else        q <= q ^ toggle;
endmodule

// File: rtl/toggle_seq_ctrl.sv
// toggle_seq_ctrl: sequences NOP/UP/DOWN/LOAD commands into per-cycle toggle vectors for a T-FF bank.
// Define TOGGLE_SEQ_SATURATE_EN to hold q at the boundary instead of wrapping modulo 2^WIDTH.
module toggle_seq_ctrl
    import toggle_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             busy,
    output logic [WIDTH-1:0] toggle,
    output logic [WIDTH-1:0] q,
    output logic             done,
    output logic             wrap
);
    logic             st;
    logic [1:0]       op;
    logic [WIDTH-1:0] data, up_t, dn_t, step_t;
    logic [LEN_W-1:0] cnt;
    logic             live, last, bound;

    assign cmd_ready = st == ST_IDLE;
    assign busy      = st == ST_RUN;
    assign live      = cnt != '0;
    assign last      = cnt <= LEN_W'(1);
    assign bound     = (op == OP_UP && &q) || (op == OP_DOWN && ~|q);

    // carry/borrow chains of a binary counter expressed as T-FF toggles
    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign up_t[i] = &q[i-1:0];
        assign dn_t[i] = ~|q[i-1:0];
    end

    always_comb
        step_t = op == OP_LOAD ? q ^ data :
                 op == OP_UP   ? up_t     :
                 op == OP_DOWN ? dn_t     : '0;

`ifdef TOGGLE_SEQ_SATURATE_EN
    assign toggle = busy && live && !bound ? step_t : '0;
`else
    assign toggle = busy && live ? step_t : '0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            st   <= ST_IDLE;
            op   <= OP_NOP;
            data <= '0;
            cnt  <= '0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            done <= busy && last;
            wrap <= busy && live && bound;
            if (cmd_ready && cmd_valid) begin
                st   <= ST_RUN;
                op   <= cmd_op;
                data <= cmd_data;
                // NOP/LOAD take exactly one step regardless of cmd_len
                cnt  <= (cmd_op == OP_UP || cmd_op == OP_DOWN) ? cmd_len : LEN_W'(1);
            end else if (busy) begin
                st  <= last ? ST_IDLE : ST_RUN;
                cnt <= live ? cnt - LEN_W'(1) : cnt;
            end
        end

    t_ff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .toggle (toggle),
        .q      (q)
    );
endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// tb_toggle_seq_ctrl: directed vectors with hand-computed expectations for toggle_seq_ctrl.
module tb_toggle_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = '0;
    logic [7:0] cmd_len = '0;
    logic       busy, done, wrap;
    logic [7:0] toggle, q;
    int         n_vec = 0;
    int         n_bad = 0;

    toggle_seq_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .busy      (busy),
        .toggle    (toggle),
        .q         (q),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // returns at the negedge of the first RUN cycle
    task automatic issue(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_q", q, 8'h00);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_toggle", toggle, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: abort UP len=5 after two steps
        issue(2'b01, 8'h00, 8'd5);
        @(negedge clk);
        @(negedge clk);
        chk("t1_q2", q, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("t1_q", q, 8'h00);
        chk("t1_busy", busy, 0);
        chk("t1_ready", cmd_ready, 1);
        chk("t1_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_done_after", done, 0);
        chk("t1_busy_after", busy, 0);

        // 2: LOAD A5, len ignored
        issue(2'b11, 8'hA5, 8'd7);
        chk("t2_toggle", toggle, 8'hA5);
        chk("t2_done0", done, 0);
        @(negedge clk);
        chk("t2_q", q, 8'hA5);
        chk("t2_done", done, 1);
        chk("t2_toggle_idle", toggle, 0);
        @(negedge clk);
        chk("t2_done_pulse", done, 0);

        // 3: LOAD FE then UP len=3 across the all-ones boundary
        issue(2'b11, 8'hFE, 8'd0);
        @(negedge clk);
        issue(2'b01, 8'h00, 8'd3);
        chk("t3_tog1", toggle, 8'h01);
        @(negedge clk);
        chk("t3_q1", q, 8'hFF);
        chk("t3_wrap1", wrap, 0);
        @(negedge clk);
`ifdef TOGGLE_SEQ_SATURATE_EN
        chk("t3_q2", q, 8'hFF);
`else
        chk("t3_q2", q, 8'h00);
`endif
        chk("t3_wrap2", wrap, 1);
        chk("t3_done2", done, 0);
        @(negedge clk);
`ifdef TOGGLE_SEQ_SATURATE_EN
        chk("t3_q3", q, 8'hFF);
        chk("t3_wrap3", wrap, 1);
`else
        chk("t3_q3", q, 8'h01);
        chk("t3_wrap3", wrap, 0);
`endif
        chk("t3_done3", done, 1);

        // 4: LOAD 10 then DOWN len=2
        issue(2'b11, 8'h10, 8'd0);
        @(negedge clk);
        issue(2'b10, 8'h00, 8'd2);
        chk("t4_tog1", toggle, 8'h1F);
        @(negedge clk);
        chk("t4_q1", q, 8'h0F);
        chk("t4_wrap1", wrap, 0);
        chk("t4_done1", done, 0);
        @(negedge clk);
        chk("t4_q2", q, 8'h0E);
        chk("t4_wrap2", wrap, 0);
        chk("t4_done2", done, 1);
        @(negedge clk);
        chk("t4_done_once", done, 0);

        // 5: second command held during RUN, accepted in the done cycle
        issue(2'b01, 8'h00, 8'd2);
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_data  = 8'h55;
        chk("t5_ready_run", cmd_ready, 0);
        @(negedge clk);
        chk("t5_q1", q, 8'h0F);
        chk("t5_busy1", busy, 1);
        @(negedge clk);
        chk("t5_q2", q, 8'h10);
        chk("t5_done", done, 1);
        chk("t5_ready", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t5_busy2", busy, 1);
        chk("t5_tog", toggle, 8'h45);
        @(negedge clk);
        chk("t5_q3", q, 8'h55);
        chk("t5_done3", done, 1);

        // 6: UP len=0 and NOP each take a single idle RUN cycle
        issue(2'b01, 8'h00, 8'd0);
        chk("t6_busy_up", busy, 1);
        chk("t6_tog_up", toggle, 0);
        @(negedge clk);
        chk("t6_done_up", done, 1);
        chk("t6_q_up", q, 8'h55);
        chk("t6_wrap_up", wrap, 0);
        issue(2'b00, 8'hFF, 8'd9);
        chk("t6_busy_nop", busy, 1);
        chk("t6_tog_nop", toggle, 0);
        @(negedge clk);
        chk("t6_done_nop", done, 1);
        chk("t6_q_nop", q, 8'h55);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
